// File: rtl/serial_tx_pkg.sv
// Shared state encoding and line levels for the framed serial transmitter.
package serial_tx_pkg;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_START  = 3'd1,
      ST_DATA   = 3'd2,
      ST_PARITY = 3'd3,
      ST_STOP   = 3'd4
   } tx_state_e;

   localparam logic IDLE_LVL  = 1'b1;
   localparam logic START_LVL = 1'b0;
   localparam logic STOP_LVL  = 1'b1;

endpackage

// File: rtl/serial_tx_baud.sv
// Bit-period counter: counts 0..DIV-1 and wraps, ticks bit_end_o on the last clock of each bit.
// last_next_o flags that the following cycle will be the last clock of a bit.
module serial_tx_baud #(
   parameter int DIV = 10
) (
   input  logic clk,
   input  logic reset,
   input  logic clr_i,
   output logic bit_end_o,
   output logic last_next_o
);

   localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
   localparam logic [CW-1:0] LAST = CW'(DIV - 1);

   logic [CW-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clr_i || (cnt_q == LAST)) begin
         cnt_d = '0;
      end else begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign bit_end_o   = (cnt_q == LAST) & ~clr_i;
   assign last_next_o = (cnt_d == LAST);

endmodule

// File: rtl/serial_word_tx.sv
// LSB-first framed serial transmitter: start, N data bits, optional even parity, stop; DIV clocks per bit.
// One word per frame, accepted only in IDLE; SERIAL_WORD_TX_PARITY_EN inserts the parity bit.
module serial_word_tx
   import serial_tx_pkg::*;
#(
   parameter int N   = 4,
   parameter int DIV = 10
) (
   input  logic         clk,
   input  logic         reset,
   input  logic [N-1:0] din,
   input  logic         load_valid,
   output logic         load_ready,
   output logic         dout,
   output logic         busy,
   output logic         done
);

   localparam int BW = $clog2(N) + 1;
   localparam logic [BW-1:0] LAST_BIT = BW'(N - 1);

   tx_state_e     state_q, state_d;
   logic [N-1:0]  shift_q, shift_d;
   logic [BW-1:0] bit_cnt_q, bit_cnt_d;
   logic          dout_q, dout_d;
   logic          busy_q, busy_d;
   logic          done_q, done_d;
   logic          bit_end;
   logic          last_next;
`ifdef SERIAL_WORD_TX_PARITY_EN
   logic          par_q, par_d;
`endif

   serial_tx_baud #(
      .DIV (DIV)
   ) u_baud (
      .clk         (clk),
      .reset       (reset),
      .clr_i       (state_q == ST_IDLE),
      .bit_end_o   (bit_end),
      .last_next_o (last_next)
   );

   always_comb begin
      state_d   = state_q;
      shift_d   = shift_q;
      bit_cnt_d = bit_cnt_q;
`ifdef SERIAL_WORD_TX_PARITY_EN
      par_d     = par_q;
`endif
      case (state_q)
         ST_IDLE: begin
            if (load_valid) begin
               shift_d   = din;
               bit_cnt_d = '0;
`ifdef SERIAL_WORD_TX_PARITY_EN
               par_d     = ^din;
`endif
               state_d   = ST_START;
            end
         end
         ST_START: begin
            if (bit_end) state_d = ST_DATA;
         end
         ST_DATA: begin
            if (bit_end) begin
               shift_d   = {1'b0, shift_q[N-1:1]};
               bit_cnt_d = bit_cnt_q + 1'b1;
               if (bit_cnt_q == LAST_BIT) begin
`ifdef SERIAL_WORD_TX_PARITY_EN
                  state_d = ST_PARITY;
`else
                  state_d = ST_STOP;
`endif
               end
            end
         end
`ifdef SERIAL_WORD_TX_PARITY_EN
         ST_PARITY: begin
            if (bit_end) state_d = ST_STOP;
         end
`endif
         ST_STOP: begin
            if (bit_end) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase

      // Outputs are registered, so they are decoded from the upcoming state.
      case (state_d)
         ST_START:  dout_d = START_LVL;
         ST_DATA:   dout_d = shift_d[0];
`ifdef SERIAL_WORD_TX_PARITY_EN
         ST_PARITY: dout_d = par_d;
`endif
         ST_STOP:   dout_d = STOP_LVL;
         default:   dout_d = IDLE_LVL;
      endcase
      busy_d = (state_d != ST_IDLE);
      done_d = (state_d == ST_STOP) && last_next;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= ST_IDLE;
         shift_q   <= '0;
         bit_cnt_q <= '0;
         dout_q    <= IDLE_LVL;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
`ifdef SERIAL_WORD_TX_PARITY_EN
         par_q     <= 1'b0;
`endif
      end else begin
         state_q   <= state_d;
         shift_q   <= shift_d;
         bit_cnt_q <= bit_cnt_d;
         dout_q    <= dout_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
`ifdef SERIAL_WORD_TX_PARITY_EN
         par_q     <= par_d;
`endif
      end
   end

   assign load_ready = (state_q == ST_IDLE);
   assign dout       = dout_q;
   assign busy       = busy_q;
   assign done       = done_q;

endmodule
